dmem_responder: RTL and testbench
=================================

// Module: dmem_responder
// PURPOSE
//   Data-memory responder on the memory stage of the pipelined ARM core. Serves
//   loads and stores issued from the memory stage (ALUOutM address, WriteDataM
//   store data) and returns ReadData.
//   Models a memory with WAIT programmable wait states. Raises StallM toward the
//   hazard unit until the access completes, so the pipeline holds steady.
// PARAMETERS
//   AW    8   word-address width; storage is 2**AW x 32-bit words
//   WAIT  0   wait states per access (0..15); 0 = single-cycle memory
// PORTS
//   clk        in   1   pipeline clock, rising-edge
//   reset      in   1   asynchronous, active-high
//   MemReqM    in   1   memory-stage instruction is a load or a store
//   MemWriteM  in   1   1 = store, 0 = load (qualified by MemReqM)
//   ALUOutM    in   32  byte address; word index = ALUOutM[AW+1:2]
//   WriteDataM in   32  store data
//   ReadData   out  32  load data, valid in the completion cycle only
//   StallM     out  1   access in progress; hazard unit freezes F/D/E/M
//   MemErr     out  1   misaligned-access pulse (DMEM_ALIGN_CHECK_EN only)
// BEHAVIOUR
//   Reset: state=IDLE, counter=0, latches=0; StallM=0, ReadData=0, MemErr=0.
//     Storage array is NOT cleared. Reset mid-access aborts it; pending store is dropped.
//   WAIT==0: no FSM activity; StallM tied 0. ReadData=mem[idx] combinationally
//     while MemReqM&!MemWriteM, else 0. Store written at rising edge when MemReqM&MemWriteM.
//   WAIT>0 FSM: IDLE -> BUSY -> DONE -> IDLE.
//     IDLE: MemReqM=1 -> latch addr/we/wdata; StallM=1 this cycle; load cnt=WAIT-1;
//       next state DONE if WAIT==1, else BUSY.
//     BUSY: StallM=1; cnt decrements; cnt==1 -> DONE.
//     DONE: StallM=0; access performed from latched values. Load: ReadData=mem[idx].
//       Store: write at the closing edge. Next state IDLE.
//   StallM is high for exactly WAIT consecutive cycles, from the cycle the request is
//     first seen in IDLE; completion is in cycle WAIT+1.
//   Input changes while BUSY/DONE are ignored (latched copy is used).
//   Back-to-back: the cycle after DONE is IDLE. If MemReqM is still high there, it is
//     a new request (pipeline has advanced).
//   ReadData=0 in every non-completion cycle and on stores.
//   Address wrap: ALUOutM[31:AW+2] ignored, index wraps modulo 2**AW.
//   Same-word read after write: returns the newly written value (store committed first).
// CONFIGURATION
//   DMEM_ALIGN_CHECK_EN defined: ALUOutM[1:0]!=0 on a completing access gives:
//     MemErr=1 for that single cycle; store suppressed; ReadData=0.
//     StallM timing is unchanged.
//   Not defined: ALUOutM[1:0] ignored; MemErr tied 0.
// TESTING
//   1 WAIT=0: store 0xDEADBEEF @0x10, then load @0x10 -> ReadData=0xDEADBEEF
//     same cycle, StallM=0 throughout.
//   2 WAIT=3: load @0x20 (mem=0x12345678) -> StallM=1 cycles 0..2;
//     cycle 3 StallM=0, ReadData=0x12345678; cycle 4 ReadData=0.
//   3 WAIT=2: store 0xA5A5A5A5 @0x04, change ALUOutM to 0x08 while stalled
//     -> only word 1 written, word 2 unchanged.
//   4 WAIT=4: assert reset in cycle 2 of a store -> StallM=0 next cycle,
//     target word keeps old value, FSM IDLE.
//   5 AW=4: load @0x44 -> same word as @0x04 (wrap).
//   6 DMEM_ALIGN_CHECK_EN: store @0x06 -> MemErr=1 one cycle, memory unchanged;
//     without the macro the store lands at word 1.

Source files
------------

// File: rtl/dmem_responder.sv
// Data-memory responder for the memory stage: WAIT programmable wait states, StallM to hazard unit.
// Optional misaligned-access detection enabled by defining DMEM_ALIGN_CHECK_EN.
//
// state | meaning
// IDLE  | no access in flight; a request here is latched and starts the stall
// BUSY  | wait states elapsing; counter runs down to terminal count 1
// DONE  | completion cycle; access performed from the latched copy
module dmem_responder #(
    parameter int AW   = 8,
    parameter int WAIT = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemReqM,
    input  logic        MemWriteM,
    input  logic [31:0] ALUOutM,
    input  logic [31:0] WriteDataM,
    output logic [31:0] ReadData,
    output logic        StallM,
    output logic        MemErr
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    logic [31:0]   mem [2**AW];
    logic          acc_fire;
    logic          acc_we;
    logic [AW+1:0] acc_addr;
    logic [31:0]   acc_wdata;
    logic          acc_bad;

    // Upper address bits fold away: the index wraps modulo 2**AW.
    logic unused_hi;
    assign unused_hi = ^ALUOutM[31:AW+2];

    generate
        if (WAIT == 0) begin : g_comb
            assign acc_fire  = MemReqM & ~reset;
            assign acc_we    = MemWriteM;
            assign acc_addr  = ALUOutM[AW+1:0];
            assign acc_wdata = WriteDataM;
            assign StallM    = 1'b0;
        end else begin : g_fsm
            state_t        state, state_nxt;
            logic [3:0]    cnt, cnt_nxt;
            logic          stall;
            logic          lat_we;
            logic [AW+1:0] lat_addr;
            logic [31:0]   lat_wdata;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    state     <= IDLE;
                    cnt       <= '0;
                    lat_we    <= 1'b0;
                    lat_addr  <= '0;
                    lat_wdata <= '0;
                end else begin
                    state <= state_nxt;
                    cnt   <= cnt_nxt;
                    if (state == IDLE && MemReqM) begin
                        lat_we    <= MemWriteM;
                        lat_addr  <= ALUOutM[AW+1:0];
                        lat_wdata <= WriteDataM;
                    end
                end
            end

            always_comb begin
                state_nxt = state;
                cnt_nxt   = cnt;
                stall     = 1'b0;
                case (state)
                    IDLE: begin
                        if (MemReqM) begin
                            stall     = 1'b1;
                            cnt_nxt   = 4'(WAIT - 1);
                            state_nxt = (WAIT == 1) ? DONE : BUSY;
                        end
                    end
                    BUSY: begin
                        stall   = 1'b1;
                        cnt_nxt = cnt - 4'd1;
                        if (cnt == 4'd1)
                            state_nxt = DONE;
                    end
                    DONE:    state_nxt = IDLE;
                    default: state_nxt = IDLE;
                endcase
            end

            assign StallM    = stall;
            assign acc_fire  = (state == DONE);
            assign acc_we    = lat_we;
            assign acc_addr  = lat_addr;
            assign acc_wdata = lat_wdata;
        end
    endgenerate

`ifdef DMEM_ALIGN_CHECK_EN
    assign acc_bad = acc_fire && (acc_addr[1:0] != 2'b00);
`else
    logic unused_lsb;
    assign unused_lsb = ^acc_addr[1:0];
    assign acc_bad    = 1'b0;
`endif

    assign MemErr = acc_bad;

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (acc_fire && acc_we && !acc_bad)
            mem[acc_addr[AW+1:2]] <= acc_wdata;
    end

    assign ReadData = (acc_fire && !acc_we && !acc_bad) ? mem[acc_addr[AW+1:2]] : 32'h0;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: five instances with WAIT=0..4 (the WAIT=4 one has AW=4).
// Honours DMEM_ALIGN_CHECK_EN in its expectations when the build defines it.
module tb_dmem_responder;

    localparam int N = 5;

    logic        clk = 1'b0;
    logic        reset;
    logic        req   [N];
    logic        we    [N];
    logic [31:0] addr  [N];
    logic [31:0] wd    [N];
    logic [31:0] rd    [N];
    logic        stall [N];
    logic        err   [N];

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        dmem_responder #(.AW((g == 4) ? 4 : 8), .WAIT(g)) u_dut (
            .clk       (clk),
            .reset     (reset),
            .MemReqM   (req[g]),
            .MemWriteM (we[g]),
            .ALUOutM   (addr[g]),
            .WriteDataM(wd[g]),
            .ReadData  (rd[g]),
            .StallM    (stall[g]),
            .MemErr    (err[g])
        );
    end

    typedef struct {
        int          k;
        logic [31:0] rdata;
        logic        merr;
    } exp_t;

    exp_t        sb [$];
    logic [31:0] model [N][256];
    int          n_chk = 0;
    int          n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic access(input int k, input logic w, input logic [31:0] a, input logic [31:0] d);
        int          aw;
        int          idx;
        logic [31:0] wa;
        logic        bad;
        exp_t        e;
        aw  = (k == 4) ? 4 : 8;
        wa  = a >> 2;
        idx = int'(wa) & ((1 << aw) - 1);
`ifdef DMEM_ALIGN_CHECK_EN
        bad = (a[1:0] != 2'b00);
`else
        bad = 1'b0;
`endif
        e.k     = k;
        e.rdata = (w || bad) ? 32'h0 : model[k][idx];
        e.merr  = bad;
        sb.push_back(e);

        @(posedge clk); #1;
        req[k] = 1'b1; we[k] = w; addr[k] = a; wd[k] = d;
        for (int c = 0; c < k; c++) begin
            if (c > 0) begin
                @(posedge clk); #1;
                we[k] = ~w; addr[k] = a + 32'd4; wd[k] = ~d;
            end
            @(negedge clk);
            chk($sformatf("k%0d_stall_c%0d", k, c), {31'b0, stall[k]}, 32'd1);
            chk($sformatf("k%0d_rd_busy_c%0d", k, c), rd[k], 32'h0);
        end
        if (k > 0) begin
            @(posedge clk); #1;
            we[k] = ~w; addr[k] = a + 32'd4; wd[k] = ~d;
        end
        @(negedge clk);
        e = sb.pop_front();
        chk($sformatf("k%0d_stall_done", e.k), {31'b0, stall[k]}, 32'd0);
        chk($sformatf("k%0d_rd_done_%h", e.k, a), rd[k], e.rdata);
        chk($sformatf("k%0d_err_done_%h", e.k, a), {31'b0, err[k]}, {31'b0, e.merr});
        if (w && !bad)
            model[k][idx] = d;

        @(posedge clk); #1;
        req[k] = 1'b0;
        @(negedge clk);
        chk($sformatf("k%0d_rd_after", k), rd[k], 32'h0);
        chk($sformatf("k%0d_stall_after", k), {31'b0, stall[k]}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        for (int i = 0; i < N; i++) begin
            req[i] = 1'b0; we[i] = 1'b0; addr[i] = 32'h0; wd[i] = 32'h0;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            chk($sformatf("k%0d_rst_stall", i), {31'b0, stall[i]}, 32'd0);
            chk($sformatf("k%0d_rst_rd", i), rd[i], 32'h0);
            chk($sformatf("k%0d_rst_err", i), {31'b0, err[i]}, 32'd0);
        end
        @(posedge clk); #1;
        reset = 1'b0;

        for (int k = 0; k < N; k++) begin
            access(k, 1'b1, 32'h10, 32'hDEADBEEF);
            access(k, 1'b0, 32'h10, 32'h0);
            access(k, 1'b1, 32'h20, 32'h12345678);
            access(k, 1'b0, 32'h20, 32'h0);
            access(k, 1'b1, 32'h08, 32'h0BADF00D);
            access(k, 1'b1, 32'h04, 32'hA5A5A5A5);
            access(k, 1'b0, 32'h08, 32'h0);
            access(k, 1'b0, 32'h04, 32'h0);
            access(k, 1'b1, 32'h06, 32'hBADC0DE5);
            access(k, 1'b0, 32'h04, 32'h0);
            access(k, 1'b0, 32'h06, 32'h0);
            for (int r = 0; r < 4; r++) begin
                logic [31:0] ra;
                logic [31:0] rv;
                ra = {$urandom_range(0, 15), 2'b00};
                rv = $urandom;
                access(k, 1'b1, ra, rv);
                access(k, 1'b0, ra, 32'h0);
            end
        end

        // AW=4 instance: index wraps modulo 16 words
        access(4, 1'b1, 32'h04, 32'h5555AAAA);
        access(4, 1'b0, 32'h44, 32'h0);
        access(4, 1'b1, 32'h48, 32'hC0FFEE01);
        access(4, 1'b0, 32'h08, 32'h0);

        // Reset in the third stall cycle of a WAIT=4 store must drop the store
        access(4, 1'b1, 32'h30, 32'h600DF00D);
        @(posedge clk); #1;
        req[4] = 1'b1; we[4] = 1'b1; addr[4] = 32'h30; wd[4] = 32'hFFFF0000;
        @(negedge clk);
        chk("k4_rst_mid_c0_stall", {31'b0, stall[4]}, 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("k4_rst_mid_c1_stall", {31'b0, stall[4]}, 32'd1);
        @(posedge clk); #1;
        reset = 1'b1; req[4] = 1'b0;
        @(negedge clk);
        chk("k4_rst_mid_stall", {31'b0, stall[4]}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("k4_rst_after_stall", {31'b0, stall[4]}, 32'd0);
        chk("k4_rst_after_rd", rd[4], 32'h0);
        access(4, 1'b0, 32'h30, 32'h0);
        access(3, 1'b0, 32'h10, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
